// File: rtl/mod_reduce_pkg.sv
// ============================================================================
// mod_reduce_pkg : constant functions sizing the residue-folding pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package mod_reduce_pkg;

  function automatic int clog2_c(input int unsigned v);
    int          r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned pow2_mod(input int i, input int unsigned m);
    int unsigned r;
    r = 1 % m;
    for (int k = 0; k < i; k++) r = (r * 2) % m;
    return r;
  endfunction

  // Largest value a fold can produce when every one of w input bits is set.
  function automatic int unsigned fold_sum(input int w, input int unsigned m);
    int unsigned s;
    s = 0;
    for (int i = 0; i < w; i++) s = s + pow2_mod(i, m);
    return s;
  endfunction

  function automatic int fold_width(input int k, input int in_w, input int unsigned m);
    int w;
    w = in_w;
    for (int j = 0; j < k; j++) w = clog2_c(fold_sum(w, m) + 1);
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_fold_stage.sv
// ============================================================================
// mod_fold_stage : one residue-weight fold with its valid/tag/data register
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_fold_stage
  import mod_reduce_pkg::*;
#(
  parameter int W_IN  = 16,
  parameter int W_OUT = 11,
  parameter int MOD   = 360,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W_IN-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W_OUT-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [W_OUT-1:0] term [W_IN];
  logic [W_OUT-1:0] fold;
  logic             valid_d, valid_q;
  logic [W_OUT-1:0] data_d, data_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  // Each set bit contributes its weight 2^i mod MOD.
  for (genvar i = 0; i < W_IN; i++) begin : g_term
    localparam int unsigned R = pow2_mod(i, MOD);
    assign term[i] = in_data[i] ? W_OUT'(R) : '0;
  end

  always_comb begin
    fold = '0;
    for (int i = 0; i < W_IN; i++) fold = fold + term[i];
    valid_d = in_valid;
    data_d  = in_valid ? fold : data_q;
    tag_d   = in_valid ? in_tag : tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;

endmodule

`default_nettype wire

// File: rtl/mod_reduce_pipe.sv
// ============================================================================
// mod_reduce_pipe : pipelined in_data mod MOD reducer (folds + one subtract)
// Rev 1.0
// ============================================================================
`default_nettype none

module mod_reduce_pipe
  import mod_reduce_pkg::*;
#(
  parameter int  IN_W      = 16,
  parameter int  MOD       = 360,
  parameter int  NUM_FOLDS = 3,
  parameter int  TAG_W     = 1,
  localparam int OUT_W     = clog2_c(MOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int          WF = fold_width(NUM_FOLDS, IN_W, MOD);
  localparam int unsigned SF = fold_sum(fold_width(NUM_FOLDS - 1, IN_W, MOD), MOD);
  // One spare bit keeps MOD itself representable when MOD is a power of two.
  localparam int          CW = ((WF > OUT_W) ? WF : OUT_W) + 1;

  if (SF >= 2 * MOD) begin : g_bound_err
    $fatal(1, "mod_reduce_pipe: fold bound %0d >= 2*MOD (%0d); raise NUM_FOLDS", SF, 2 * MOD);
  end

  // Fold widths never grow, so an IN_W-wide bus can carry every stage.
  logic [NUM_FOLDS:0] st_valid;
  logic [IN_W-1:0]    st_data [NUM_FOLDS+1];
  logic [TAG_W-1:0]   st_tag  [NUM_FOLDS+1];

  logic             valid0_d, valid0_q;
  logic [IN_W-1:0]  data0_d, data0_q;
  logic [TAG_W-1:0] tag0_d, tag0_q;

  always_comb begin
    valid0_d = in_valid;
    data0_d  = in_valid ? in_data : data0_q;
    tag0_d   = in_valid ? in_tag : tag0_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0_q <= 1'b0;
      data0_q  <= '0;
      tag0_q   <= '0;
    end else begin
      valid0_q <= valid0_d;
      data0_q  <= data0_d;
      tag0_q   <= tag0_d;
    end
  end

  assign st_valid[0] = valid0_q;
  assign st_data[0]  = data0_q;
  assign st_tag[0]   = tag0_q;

  for (genvar k = 1; k <= NUM_FOLDS; k++) begin : g_fold
    localparam int WI = fold_width(k - 1, IN_W, MOD);
    localparam int WO = fold_width(k, IN_W, MOD);
    logic [WO-1:0] fold_data;

    mod_fold_stage #(
      .W_IN  (WI),
      .W_OUT (WO),
      .MOD   (MOD),
      .TAG_W (TAG_W)
    ) u_fold (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (st_valid[k-1]),
      .in_data   (st_data[k-1][WI-1:0]),
      .in_tag    (st_tag[k-1]),
      .out_valid (st_valid[k]),
      .out_data  (fold_data),
      .out_tag   (st_tag[k])
    );

    assign st_data[k] = IN_W'(fold_data);
  end

  logic [CW-1:0]    x, y;
  logic             out_valid_d, out_valid_q;
  logic [OUT_W-1:0] out_data_d, out_data_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  always_comb begin
    x           = CW'(st_data[NUM_FOLDS][WF-1:0]);
    y           = (x >= CW'(MOD)) ? (x - CW'(MOD)) : x;
    out_valid_d = st_valid[NUM_FOLDS];
    out_data_d  = st_valid[NUM_FOLDS] ? OUT_W'(y) : out_data_q;
    out_tag_d   = st_valid[NUM_FOLDS] ? st_tag[NUM_FOLDS] : out_tag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

endmodule

`default_nettype wire
